if_fetch_stage: RTL

Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register and the ID stage of the 5-stage MIPS core. It owns the fetch PC and talks to instruction memory over a req/ack handshake that tolerates variable latency. It buffers fetched words in a small prefetch queue and drives the IF/ID register contents (instruction, PC+4, valid). It honours the hazard unit's stall signals and the ID-stage branch redirect/flush.

---
 rtl/if_fetch_stage.sv | 135 +++++++++++++
 1 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues single-outstanding imem
// requests, buffers responses in a prefetch queue and drives the IF/ID register.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        pc_write_i,
    input  logic        if_id_write_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] if_id_inst_o,
    output logic [31:0] if_id_pc4_o,
    output logic        if_id_valid_o
);

    localparam int unsigned AW = $clog2(QDEPTH);
    localparam int unsigned CW = $clog2(QDEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DROP
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   drop_addr_q;

    logic [31:0]   q_inst [QDEPTH];
    logic [31:0]   q_pc4  [QDEPTH];
    logic [AW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q, count_post;

    logic accept, q_empty, enq, deq;
    logic issue_pre, issue_post;

    always_comb begin
        accept     = (state_q == REQ) && imem_ack_i && !branch_i;
        q_empty    = (count_q == '0);
        deq        = !branch_i && if_id_write_i && !q_empty;
        // An accepted response bypasses the queue when IF/ID loads from an empty queue.
        enq        = accept && !(if_id_write_i && q_empty);
        count_post = count_q + CW'(enq) - CW'(deq);
        issue_pre  = start_i && pc_write_i && !branch_i && (count_q < CW'(QDEPTH));
        issue_post = start_i && pc_write_i && !branch_i && (count_post < CW'(QDEPTH));
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            IDLE: begin
                if (issue_pre) state_d = REQ;
            end
            REQ: begin
                if (branch_i) begin
                    state_d = imem_ack_i ? IDLE : DROP;
                end else if (imem_ack_i) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = issue_post ? REQ : IDLE;
                end
            end
            DROP: begin
                if (imem_ack_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (branch_i) pc_d = branch_target_i & ~32'h3;

        imem_req_o  = (state_q != IDLE);
        imem_addr_o = (state_q == DROP) ? drop_addr_q : pc_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            drop_addr_q   <= RESET_PC;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            if_id_inst_o  <= '0;
            if_id_pc4_o   <= '0;
            if_id_valid_o <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            // The abandoned request keeps its address on the bus until it completes.
            if ((state_q == REQ) && branch_i && !imem_ack_i) drop_addr_q <= pc_q;

            if (branch_i) begin
                head_q        <= '0;
                tail_q        <= '0;
                count_q       <= '0;
                if_id_inst_o  <= '0;
                if_id_pc4_o   <= '0;
                if_id_valid_o <= 1'b0;
            end else begin
                if (enq) tail_q <= tail_q + AW'(1);
                if (deq) head_q <= head_q + AW'(1);
                count_q <= count_post;
                if (if_id_write_i) begin
                    if (!q_empty) begin
                        if_id_inst_o  <= q_inst[head_q];
                        if_id_pc4_o   <= q_pc4[head_q];
                        if_id_valid_o <= 1'b1;
                    end else if (accept) begin
                        if_id_inst_o  <= imem_rdata_i;
                        if_id_pc4_o   <= pc_q + 32'd4;
                        if_id_valid_o <= 1'b1;
                    end else begin
                        if_id_inst_o  <= '0;
                        if_id_pc4_o   <= '0;
                        if_id_valid_o <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && enq) begin
            q_inst[tail_q] <= imem_rdata_i;
            q_pc4[tail_q]  <= pc_q + 32'd4;
        end
    end

endmodule
